wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Synthesizable write-back trace recorder for the pipelined MIPS CPU. It sits beside the WB stage and snoops the register-file write port (write enable, destination register, write data, PC+4). Each qualifying write is captured with a cycle stamp into a parametrised circular buffer, so self-checking benches and on-chip debug can replay the architectural write sequence in order instead of hand-probing pipeline registers.

## Interface
Parameters:
- DATA_W, 32, width of write data and PC
- REG_W, 5, width of register index
- DEPTH, 16, number of entries; power of two, ≥2
- CYC_W, 16, width of cycle stamp

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- wb_en  in  1  register-file write enable from WB
- wb_rd  in  REG_W  destination register
- wb_data  in  DATA_W  write-back data
- wb_pc  in  DATA_W  PC+4 of the writing instruction
- arm  in  1  start a new capture
- stop  in  1  end the capture
- wrap_mode  in  1  1 = overwrite oldest when full; 0 = auto-stop when full
- filter_en  in  1  capture only writes to filter_rd
- filter_rd  in  REG_W  register selected by the filter
- rd_req  in  1  pop the oldest entry
- rd_valid  out  1  one-cycle strobe; rd_* fields valid
- rd_reg  out  REG_W  popped register index
- rd_data  out  DATA_W  popped write data
- rd_pc  out  DATA_W  popped PC+4
- rd_cycle  out  CYC_W  popped cycle stamp
- count  out  log2(DEPTH)+1  entries held
- full  out  1  count == DEPTH
- capturing  out  1  state is CAPTURE
- overflow  out  1  sticky; an entry was overwritten

## Operation
- States: IDLE, CAPTURE, DONE. rst_n=0 forces IDLE.
- IDLE/DONE --arm--> CAPTURE. On entry: pointers, count and overflow are cleared, and the cycle counter is set to 0. arm while in CAPTURE is ignored.
- CAPTURE --stop--> DONE.
- CAPTURE --(write that fills the buffer, with wrap_mode=0)--> DONE.
- Qualifying event: all of the following hold in CAPTURE.
  - wb_en=1
  - wb_rd≠0 (writes to $zero are never recorded)
  - filter_en=0, or wb_rd==filter_rd
- Each qualifying event writes {wb_rd, wb_data, wb_pc, cycle} at the write pointer, advances the pointer (mod DEPTH) and increments count.
- Full with wrap_mode=1:
  - the new entry overwrites the oldest
  - the read pointer advances
  - count stays at DEPTH
  - overflow sets and stays set until the next arm
- Full with wrap_mode=0: no further events are recorded.
- Cycle counter: increments every cycle in CAPTURE and saturates at 2^CYC_W−1. The first CAPTURE cycle is stamp 0.
- Readout:
  - rd_req is honoured only in DONE with count>0.
  - Each honoured request pops the oldest entry and decrements count.
  - rd_req in any other case is ignored; rd_valid stays 0 and no state changes.
- The buffer contents in DONE are preserved until the next arm or reset.

## Timing
- Reset values: rd_valid, rd_reg, rd_data, rd_pc, rd_cycle, count, full, capturing, overflow are all 0; state is IDLE.
- arm sampled at edge N: capturing=1 after edge N. An event present at edge N is not recorded.
- An event sampled at edge N is reflected in count/full after edge N.
- stop and an event at the same edge: the event is recorded, then the state is DONE.
- Auto-stop: the DEPTH-th write at edge N gives full=1 and capturing=0 after edge N.
- rd_req at edge N gives rd_valid=1 with the entry for one cycle after edge N; count decrements at the same edge.
- Back-to-back rd_req: one entry per cycle, no bubbles, oldest first.
- rd_req on the edge that takes count to 0 is the last valid pop. The next rd_req is ignored.
- arm and rd_req at the same edge in DONE: arm wins, no pop, rd_valid=0.
- Reset is synchronous. rst_n=0 mid-capture or mid-readout clears everything at the next edge; buffer RAM contents are don't-care.

## Test plan
- Reset, then arm; writes $8=5 at stamp 2 and $9=7 at stamp 4; stop; two rd_req -> rd_valid pulses return {8,5,pc,2}, then {9,7,pc,4}; count 2→1→0.
- DEPTH=4, wrap_mode=0, six writes -> auto-stop after the 4th; full=1, capturing=0; readout returns the first four; overflow=0.
- DEPTH=4, wrap_mode=1, six writes (rd 1..6), stop -> count=4, overflow=1; readout returns rd 3,4,5,6.
- Write to $0 and filter_en=1 with filter_rd=9 among writes to 8, 9, 9 -> only two $9 entries recorded.
- rd_req during CAPTURE and rd_req with count=0 in DONE -> rd_valid=0 and no change. arm+rd_req at the same edge -> new capture, count=0.
- rst_n=0 for one cycle mid-capture with count=3 -> all outputs 0 and state IDLE at the next edge.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Write-back trace recorder: snoops the register-file write port and logs each
// qualifying write with a cycle stamp into a circular buffer for ordered replay.
module wb_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 16,
   parameter int CYC_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wb_en,
   input  logic [REG_W-1:0]           wb_rd,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic [DATA_W-1:0]          wb_pc,
   input  logic                       arm,
   input  logic                       stop,
   input  logic                       wrap_mode,
   input  logic                       filter_en,
   input  logic [REG_W-1:0]           filter_rd,
   input  logic                       rd_req,
   output logic                       rd_valid,
   output logic [REG_W-1:0]           rd_reg,
   output logic [DATA_W-1:0]          rd_data,
   output logic [DATA_W-1:0]          rd_pc,
   output logic [CYC_W-1:0]           rd_cycle,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       capturing,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = REG_W + 2 * DATA_W + CYC_W;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   cnt;
   logic [CYC_W-1:0]   cyc;
   logic               ovf;
   logic [ENT_W-1:0]   mem [DEPTH];

   logic               qualify, is_full, do_write, do_wrap, do_arm, do_pop;

   function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Stage p0: event qualification and control decode
   always_comb begin
      qualify  = (state_q == S_CAPTURE) && wb_en && (wb_rd != '0) &&
                 (!filter_en || (wb_rd == filter_rd));
      is_full  = (cnt == CNT_W'(DEPTH));
      do_write = qualify && (!is_full || wrap_mode);
      do_wrap  = do_write && is_full;
      do_arm   = arm && (state_q != S_CAPTURE);
      // arm has priority over a pop issued on the same edge
      do_pop   = (state_q == S_DONE) && rd_req && (cnt != '0) && !arm;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (arm) state_d = S_CAPTURE;
         S_CAPTURE: if (stop || (do_write && !wrap_mode && cnt == CNT_W'(DEPTH - 1)))
                       state_d = S_DONE;
         S_DONE:    if (arm) state_d = S_CAPTURE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Stage p1: state, pointers, counters and readout register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         cyc      <= '0;
         ovf      <= 1'b0;
         rd_valid <= 1'b0;
         rd_reg   <= '0;
         rd_data  <= '0;
         rd_pc    <= '0;
         rd_cycle <= '0;
      end else begin
         state_q  <= state_d;
         rd_valid <= do_pop;
         if (do_arm) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            cyc    <= '0;
            ovf    <= 1'b0;
         end else begin
            if (state_q == S_CAPTURE) cyc <= sat_inc(cyc);
            if (do_write) begin
               wr_ptr <= wr_ptr + 1'b1;
               if (do_wrap) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  ovf    <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + 1'b1;
               cnt    <= cnt - 1'b1;
               {rd_reg, rd_data, rd_pc, rd_cycle} <= mem[rd_ptr];
            end
         end
      end
   end

   // Trace storage has no reset; contents are only meaningful after an arm
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr] <= {wb_rd, wb_data, wb_pc, cyc};
   end

   assign count     = cnt;
   assign full      = is_full;
   assign capturing = (state_q == S_CAPTURE);
   assign overflow  = ovf;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: directed scenarios plus random traffic, checked
// against a queue-based model of the trace recorder.
module tb_wb_trace_buffer;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int DEPTH  = 4;
   localparam int CYC_W  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int CYC_MAX = (1 << CYC_W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, wb_en, arm, stop, wrap_mode, filter_en, rd_req;
   logic [REG_W-1:0]  wb_rd, filter_rd;
   logic [DATA_W-1:0] wb_data, wb_pc;
   logic              rd_valid, full, capturing, overflow;
   logic [REG_W-1:0]  rd_reg;
   logic [DATA_W-1:0] rd_data, rd_pc;
   logic [CYC_W-1:0]  rd_cycle;
   logic [CNT_W-1:0]  count;

   wb_trace_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
      .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_pc(wb_pc), .arm(arm), .stop(stop), .wrap_mode(wrap_mode),
      .filter_en(filter_en), .filter_rd(filter_rd), .rd_req(rd_req),
      .rd_valid(rd_valid), .rd_reg(rd_reg), .rd_data(rd_data), .rd_pc(rd_pc),
      .rd_cycle(rd_cycle), .count(count), .full(full), .capturing(capturing),
      .overflow(overflow)
   );

   typedef struct packed {
      logic [REG_W-1:0]  r;
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] p;
      logic [CYC_W-1:0]  c;
   } ent_t;

   // Reference model: 0 = idle, 1 = capturing, 2 = done
   ent_t q[$];
   int   m_state;
   int   m_cyc;
   bit   m_ovf, m_rdv;
   ent_t m_rd;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_start();
      q.delete();
      m_cyc   = 0;
      m_ovf   = 0;
      m_state = 1;
   endtask

   task automatic model_edge();
      ent_t e;
      if (!rst_n) begin
         q.delete();
         m_state = 0; m_cyc = 0; m_ovf = 0; m_rdv = 0; m_rd = '0;
         return;
      end
      m_rdv = 0;
      case (m_state)
         0: if (arm) m_start();
         1: begin
            if (wb_en && wb_rd != 0 && (!filter_en || wb_rd == filter_rd)) begin
               e.r = wb_rd; e.d = wb_data; e.p = wb_pc; e.c = CYC_W'(m_cyc);
               if (q.size() < DEPTH) begin
                  q.push_back(e);
                  if (q.size() == DEPTH && !wrap_mode) m_state = 2;
               end else if (wrap_mode) begin
                  void'(q.pop_front());
                  q.push_back(e);
                  m_ovf = 1;
               end
            end
            if (m_cyc < CYC_MAX) m_cyc++;
            if (stop) m_state = 2;
         end
         default: begin
            if (arm) m_start();
            else if (rd_req && q.size() > 0) begin
               m_rd  = q.pop_front();
               m_rdv = 1;
            end
         end
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
      chk("count", 64'(count), 64'(q.size()));
      chk("full", 64'(full), 64'(q.size() == DEPTH));
      chk("capturing", 64'(capturing), 64'(m_state == 1));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("rd_reg", 64'(rd_reg), 64'(m_rd.r));
      chk("rd_data", 64'(rd_data), 64'(m_rd.d));
      chk("rd_pc", 64'(rd_pc), 64'(m_rd.p));
      chk("rd_cycle", 64'(rd_cycle), 64'(m_rd.c));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
      wb_en = 1; wb_rd = r; wb_data = d; wb_pc = 32'h0040_0000 + {d[29:0], 2'b00};
      step();
      wb_en = 0;
   endtask

   task automatic do_arm();  arm  = 1; step(); arm  = 0; endtask
   task automatic do_stop(); stop = 1; step(); stop = 0; endtask
   task automatic pop();     rd_req = 1; step(); rd_req = 0; endtask

   initial begin
      rst_n = 0; wb_en = 0; wb_rd = '0; wb_data = '0; wb_pc = '0; arm = 0; stop = 0;
      wrap_mode = 0; filter_en = 0; filter_rd = '0; rd_req = 0;
      step();
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_capturing", 64'(capturing), 64'd0);
      rst_n = 1;
      idle(2);

      // Basic capture and ordered readout with stamps 2 and 4
      do_arm();
      idle(2);
      wr(5'd8, 32'd5);
      idle(1);
      wr(5'd9, 32'd7);
      do_stop();
      chk("t1_count2", 64'(count), 64'd2);
      pop();
      chk("t1_pop1_reg", 64'(rd_reg), 64'd8);
      chk("t1_pop1_data", 64'(rd_data), 64'd5);
      chk("t1_pop1_cyc", 64'(rd_cycle), 64'd2);
      chk("t1_count1", 64'(count), 64'd1);
      pop();
      chk("t1_pop2_reg", 64'(rd_reg), 64'd9);
      chk("t1_pop2_cyc", 64'(rd_cycle), 64'd4);
      chk("t1_count0", 64'(count), 64'd0);
      pop();
      chk("t1_empty_pop", 64'(rd_valid), 64'd0);

      // Auto-stop when full without wrap
      wrap_mode = 0;
      do_arm();
      for (int i = 1; i <= 6; i++) wr(REG_W'(i), 32'(i * 3));
      chk("t2_full", 64'(full), 64'd1);
      chk("t2_capturing", 64'(capturing), 64'd0);
      chk("t2_overflow", 64'(overflow), 64'd0);
      for (int i = 1; i <= 4; i++) begin
         pop();
         chk("t2_pop_reg", 64'(rd_reg), 64'(i));
      end

      // Wrap mode keeps the newest DEPTH entries
      wrap_mode = 1;
      do_arm();
      for (int i = 1; i <= 6; i++) wr(REG_W'(i), 32'(100 + i));
      do_stop();
      chk("t3_count", 64'(count), 64'd4);
      chk("t3_overflow", 64'(overflow), 64'd1);
      rd_req = 1;
      for (int i = 3; i <= 6; i++) begin
         step();
         chk("t3_pop_reg", 64'(rd_reg), 64'(i));
      end
      rd_req = 0;
      wrap_mode = 0;

      // $zero and register filter
      do_arm();
      filter_en = 1; filter_rd = 5'd9;
      wr(5'd0, 32'd1);
      wr(5'd8, 32'd2);
      wr(5'd9, 32'd3);
      wr(5'd9, 32'd4);
      do_stop();
      filter_en = 0;
      chk("t4_count", 64'(count), 64'd2);
      pop();
      chk("t4_pop_data", 64'(rd_data), 64'd3);

      // Ignored reads, then arm beating rd_req
      do_arm();
      wr(5'd3, 32'd30);
      pop();
      chk("t5_cap_pop", 64'(rd_valid), 64'd0);
      do_stop();
      pop();
      pop();
      chk("t5_empty_pop", 64'(rd_valid), 64'd0);
      do_arm();
      wr(5'd4, 32'd40);
      do_stop();
      arm = 1; rd_req = 1;
      step();
      arm = 0; rd_req = 0;
      chk("t5_arm_wins_cnt", 64'(count), 64'd0);
      chk("t5_arm_wins_vld", 64'(rd_valid), 64'd0);
      chk("t5_arm_wins_cap", 64'(capturing), 64'd1);

      // Reset mid-capture
      wr(5'd1, 32'd1); wr(5'd2, 32'd2); wr(5'd3, 32'd3);
      chk("t6_count3", 64'(count), 64'd3);
      rst_n = 0;
      step();
      rst_n = 1;
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_capturing", 64'(capturing), 64'd0);
      chk("t6_rd_reg", 64'(rd_reg), 64'd0);
      do_arm();
      chk("t6_after_rst_arm", 64'(capturing), 64'd1);
      do_stop();

      // Cycle stamp saturation
      do_arm();
      idle(CYC_MAX + 5);
      wr(5'd7, 32'd77);
      do_stop();
      pop();
      chk("t7_sat_cyc", 64'(rd_cycle), 64'(CYC_MAX));

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         wb_en     = ($urandom_range(0, 2) != 0);
         wb_rd     = REG_W'($urandom_range(0, 7));
         wb_data   = $urandom;
         wb_pc     = $urandom;
         arm       = ($urandom_range(0, 24) == 0);
         stop      = ($urandom_range(0, 14) == 0);
         wrap_mode = ($urandom_range(0, 1) == 1);
         filter_en = ($urandom_range(0, 5) == 0);
         filter_rd = REG_W'($urandom_range(0, 7));
         rd_req    = ($urandom_range(0, 1) == 1);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
